// File: rtl/force_accum_cache_pkg.sv
// force_accum_cache_pkg
// Shared definitions for the force accumulator cache: default sizes, the
// {Fz, Fy, Fx} force vector type, per-component slice helper, the
// saturating component adder and the controller state encoding.
package force_accum_cache_pkg;

    localparam int FA_DATA_WIDTH   = 32;
    localparam int FA_PARTICLE_NUM = 290;
    localparam int FA_ADDR_WIDTH   = 9;

    typedef logic [FA_DATA_WIDTH-1:0]   force_comp_t;
    typedef logic [3*FA_DATA_WIDTH-1:0] force_vec_t;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_READY = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic        sat;
        force_comp_t val;
    } sat_res_t;

    // Component 0 is Fx, 1 is Fy, 2 is Fz.
    function automatic force_comp_t get_comp(input force_vec_t v, input int idx);
        return v[idx*FA_DATA_WIDTH +: FA_DATA_WIDTH];
    endfunction

    // Two's-complement add with clamping to the representable range.
    function automatic sat_res_t sat_add(input force_comp_t a, input force_comp_t b);
        logic [FA_DATA_WIDTH:0] ext;
        sat_res_t               res;
        ext = {a[FA_DATA_WIDTH-1], a} + {b[FA_DATA_WIDTH-1], b};
        // Overflow shows as disagreement between the two top bits.
        if (ext[FA_DATA_WIDTH] != ext[FA_DATA_WIDTH-1]) begin
            res.sat = 1'b1;
            res.val = ext[FA_DATA_WIDTH] ? {1'b1, {(FA_DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(FA_DATA_WIDTH-1){1'b1}}};
        end else begin
            res.sat = 1'b0;
            res.val = ext[FA_DATA_WIDTH-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/force_accum_cache_ram.sv
// force_accum_ram
// Simple dual-port RAM. Read address is sampled on the clock edge and data
// appears one cycle later; a read and a write to the same address on the
// same edge returns the old contents.
// Ports: i_clk, i_rst_n (read-data register only), i_we/i_waddr/i_wdata
// write port, i_raddr read address, o_rdata read data.
module force_accum_ram #(
    parameter int WIDTH      = 96,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_rdata;

    // Write port; storage itself is not reset (contents defined by the sweep).
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read data, old value on a same-edge write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= {WIDTH{1'b0}};
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/force_accum_cache.sv
// force_accum_cache
// Per-particle {Fz, Fy, Fx} accumulator. Partial forces are added to the
// stored value through a read-modify-write pipeline with forwarding and
// per-component saturation. A readout port returns an entry (optionally
// zeroing it) and a self-clearing sweep initialises all entries.
// Ports: i_clk, i_rst_n (async, active low); accumulate i_in_valid /
// o_in_ready / i_in_addr / i_in_force; readout i_rd_req / i_rd_addr /
// i_rd_clear -> o_rd_valid / o_rd_data; i_clear_all pulse; o_init_done
// (READY state); o_sat_flag (sticky saturation since last clear).
module force_accum_cache
    import force_accum_cache_pkg::*;
#(
    parameter int PARTICLE_NUM = FA_PARTICLE_NUM,
    parameter int ADDR_WIDTH   = FA_ADDR_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [ADDR_WIDTH-1:0]      i_in_addr,
    input  logic [3*FA_DATA_WIDTH-1:0] i_in_force,
    input  logic                       i_rd_req,
    input  logic [ADDR_WIDTH-1:0]      i_rd_addr,
    input  logic                       i_rd_clear,
    output logic                       o_rd_valid,
    output logic [3*FA_DATA_WIDTH-1:0] o_rd_data,
    input  logic                       i_clear_all,
    output logic                       o_init_done,
    output logic                       o_sat_flag
);

    localparam int DW = FA_DATA_WIDTH;
    localparam int FW = 3 * DW;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PARTICLE_NUM - 1);

    fsm_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_sweep_cnt;
    logic                  r_init_done, r_sat_flag;

    // Stage A: latched operation, its address feeds the RAM read port.
    logic                  r_a_valid, r_a_rd, r_a_clr;
    logic [ADDR_WIDTH-1:0] r_a_addr;
    force_vec_t            r_a_force;
    // Stage B: RAM data available, sum computed.
    logic                  r_b_valid, r_b_rd, r_b_clr;
    logic [ADDR_WIDTH-1:0] r_b_addr;
    force_vec_t            r_b_force;
    // Stage C: value written on the last edge (missed by B's old-data read).
    logic                  r_c_valid;
    logic [ADDR_WIDTH-1:0] r_c_addr;
    force_vec_t            r_c_data;
    // Stage D: shadow of the write one edge earlier.
    logic                  r_d_valid;
    logic [ADDR_WIDTH-1:0] r_d_addr;
    force_vec_t            r_d_data;

    logic                  r_rd_valid;
    force_vec_t            r_rd_data;

    logic                  w_in_ready, w_rd_take, w_acc_take, w_take_ok;
    logic [ADDR_WIDTH-1:0] w_take_addr;
    force_vec_t            w_q, w_operand, w_sum, w_wdata_b;
    logic                  w_sat_any;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_waddr;
    force_vec_t            w_ram_wdata;

    // Readout wins over accumulation; clear_all blocks both.
    assign w_in_ready  = (r_state == ST_READY) && !i_rd_req && !i_clear_all;
    assign w_rd_take   = (r_state == ST_READY) && i_rd_req && !i_clear_all;
    assign w_acc_take  = i_in_valid && w_in_ready;
    assign w_take_addr = w_rd_take ? i_rd_addr : i_in_addr;
    // Out-of-range addresses are accepted but never enter the pipeline.
    assign w_take_ok   = (w_rd_take || w_acc_take) && (w_take_addr <= LAST_ADDR);

    force_accum_ram #(
        .WIDTH      (FW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (r_a_addr),
        .o_rdata (w_q)
    );

    // Stage B operand forwarding: newest in-flight write first.
    always_comb begin
        if (r_c_valid && (r_c_addr == r_b_addr)) begin
            w_operand = r_c_data;
        end else if (r_d_valid && (r_d_addr == r_b_addr)) begin
            w_operand = r_d_data;
        end else begin
            w_operand = w_q;
        end
    end

    // Stage B saturating sum per component; a readout adds zero.
    always_comb begin
        force_comp_t v_addend;
        sat_res_t    v_res;
        w_sum     = {FW{1'b0}};
        w_sat_any = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v_addend = r_b_rd ? {DW{1'b0}} : get_comp(r_b_force, k);
            v_res    = sat_add(get_comp(w_operand, k), v_addend);
            w_sum[k*DW +: DW] = v_res.val;
            w_sat_any = w_sat_any | v_res.sat;
        end
        w_wdata_b = r_b_clr ? {FW{1'b0}} : w_sum;
    end

    // RAM write source: sweep zeroes in CLEAR, pipeline write-back otherwise.
    always_comb begin
        if (r_state == ST_CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_sweep_cnt;
            w_ram_wdata = {FW{1'b0}};
        end else begin
            w_ram_we    = r_b_valid;
            w_ram_waddr = r_b_addr;
            w_ram_wdata = w_wdata_b;
        end
    end

    // Controller FSM with sweep counter, init_done and sticky saturation flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_CLEAR;
            r_sweep_cnt <= {ADDR_WIDTH{1'b0}};
            r_init_done <= 1'b0;
            r_sat_flag  <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_sweep_cnt == LAST_ADDR) begin
                        r_state     <= ST_READY;
                        r_sweep_cnt <= {ADDR_WIDTH{1'b0}};
                        r_init_done <= 1'b1;
                    end else begin
                        r_sweep_cnt <= r_sweep_cnt + ADDR_WIDTH'(1);
                    end
                end
                ST_READY: begin
                    if (r_b_valid && w_sat_any) begin
                        r_sat_flag <= 1'b1;
                    end
                    if (i_clear_all) begin
                        r_state     <= ST_DRAIN;
                        r_init_done <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // A and B are the only stages with writes still to come.
                    if (!r_a_valid && !r_b_valid) begin
                        r_state     <= ST_CLEAR;
                        r_sweep_cnt <= {ADDR_WIDTH{1'b0}};
                        r_sat_flag  <= 1'b0;
                    end else if (r_b_valid && w_sat_any) begin
                        r_sat_flag <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_CLEAR;
                    r_sweep_cnt <= {ADDR_WIDTH{1'b0}};
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline stage registers A -> B -> C -> D.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_valid <= 1'b0;  r_a_rd <= 1'b0;  r_a_clr <= 1'b0;
            r_a_addr  <= {ADDR_WIDTH{1'b0}};     r_a_force <= {FW{1'b0}};
            r_b_valid <= 1'b0;  r_b_rd <= 1'b0;  r_b_clr <= 1'b0;
            r_b_addr  <= {ADDR_WIDTH{1'b0}};     r_b_force <= {FW{1'b0}};
            r_c_valid <= 1'b0;  r_c_addr <= {ADDR_WIDTH{1'b0}};  r_c_data <= {FW{1'b0}};
            r_d_valid <= 1'b0;  r_d_addr <= {ADDR_WIDTH{1'b0}};  r_d_data <= {FW{1'b0}};
        end else begin
            r_a_valid <= w_take_ok;
            r_a_rd    <= w_rd_take;
            r_a_clr   <= w_rd_take && i_rd_clear;
            r_a_addr  <= w_take_addr;
            r_a_force <= i_in_force;
            r_b_valid <= r_a_valid;
            r_b_rd    <= r_a_rd;
            r_b_clr   <= r_a_clr;
            r_b_addr  <= r_a_addr;
            r_b_force <= r_a_force;
            r_c_valid <= r_b_valid;
            r_c_addr  <= r_b_addr;
            r_c_data  <= w_wdata_b;
            r_d_valid <= r_c_valid;
            r_d_addr  <= r_c_addr;
            r_d_data  <= r_c_data;
        end
    end

    // Readout response register; data holds until the next readout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= {FW{1'b0}};
        end else begin
            r_rd_valid <= r_b_valid && r_b_rd;
            if (r_b_valid && r_b_rd) begin
                r_rd_data <= w_operand;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;
    assign o_init_done = r_init_done;
    assign o_sat_flag  = r_sat_flag;

endmodule
